// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Converts an unsigned IN_W-bit value into 8 packed BCD digits for the
// 7-segment display stage. Values above 99_999_999 are flagged through ovf
// and shown as all-ones without running the shift loop.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; bcd/ovf hold the last result
// CONV  | one double-dabble iteration per cycle, IN_W cycles; busy=1
// FIN   | result just loaded into bcd/ovf; done=1 for this cycle;
//       | a new start here is accepted (back-to-back conversions)
module bin2bcd_seq #(
    parameter int IN_W = 27
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [IN_W-1:0] bin,
    output logic            busy,
    output logic            done,
    output logic [31:0]     bcd,
    output logic            ovf
);

    localparam int              CNT_W     = 5;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(IN_W - 1);
    localparam logic [63:0]     MAX_VAL   = 64'd99_999_999;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [IN_W-1:0]   shift_q;
    logic [31:0]       work_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              accept;
    logic              in_range;
    logic              last_iter;
    logic [31:0]       work_adj;
    logic [31+IN_W:0]  cat_shifted;
    logic [31:0]       work_nxt;
    logic [IN_W-1:0]   shift_nxt;

    // start is only honoured outside CONV; a start while busy is simply dropped
    assign accept    = start && (state != CONV);
    // zero-extend before comparing so the test also works for narrow IN_W
    assign in_range  = (64'(bin) <= MAX_VAL);
    assign last_iter = (state == CONV) && (cnt_q == LAST_ITER);

    // Double-dabble step: +3 on every digit >= 5, then shift {work, shift} left
    always_comb begin
        work_adj = work_q;
        for (int i = 0; i < 8; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
        cat_shifted = {work_adj, shift_q} << 1;
        work_nxt    = cat_shifted[31+IN_W:IN_W];
        shift_nxt   = cat_shifted[IN_W-1:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = in_range ? CONV : FIN;
                end
            end
            CONV: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done = 1'b1;
                if (accept) begin
                    state_nxt = in_range ? CONV : FIN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: capture on accept, iterate in CONV, publish result on the last
    // iteration so bcd/ovf never show a partially converted value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            bcd     <= 32'h0000_0000;
            ovf     <= 1'b0;
        end else if (accept) begin
            shift_q <= bin;
            work_q  <= '0;
            cnt_q   <= '0;
            if (!in_range) begin
                bcd <= 32'hFFFF_FFFF;
                ovf <= 1'b1;
            end
        end else if (state == CONV) begin
            shift_q <= shift_nxt;
            work_q  <= work_nxt;
            cnt_q   <= cnt_q + 1'b1;
            if (last_iter) begin
                bcd <= work_nxt;
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
- REQ-001: The block SHALL have one parameter: IN_W, default 27, binary input width (27 bits covers 99_999_999, which fills 8 BCD digits).
- REQ-002: clk  input  1  sole clock; all state SHALL update on its rising edge.
- REQ-003: rst_n  input  1  reset; asynchronous and active-low.
- REQ-004: start  input  1  request to convert bin; sampled only when busy=0.
- REQ-005: bin  input  IN_W  unsigned binary value to convert.
- REQ-006: busy  output  1  high while a conversion is in progress.
- REQ-007: done  output  1  one-cycle pulse when bcd/ovf carry a new result.
- REQ-008: bcd  output  32  8 packed BCD digits, [3:0]=units ... [31:28]=10^7; feeds the 32-bit data input of the 7-segment display stage.
- REQ-009: ovf  output  1  high when the last accepted input exceeded 99_999_999.

Function
- REQ-010: The block SHALL implement FSM states IDLE, CONV and FIN; busy SHALL be 1 exactly in CONV.
- REQ-011: In IDLE or FIN with start=1, the block SHALL capture bin into a shift register, clear a 32-bit BCD work register and a 5-bit iteration counter, and go to CONV (in-range) or FIN (out-of-range).
- REQ-012: In-range means bin <= 99_999_999, tested combinationally in the accept cycle.
- REQ-013: Each CONV cycle SHALL perform one double-dabble iteration.
  - Add 3 to every work-register nibble >= 5.
  - Then shift {work, shift register} left by 1, MSB of bin first.
- REQ-014: CONV SHALL last exactly IN_W cycles; the counter SHALL count 0..IN_W-1, and the cycle with counter = IN_W-1 SHALL transition to FIN.
- REQ-015: Latency: start accepted at edge t gives busy=1 from t+1 through t+IN_W (27 cycles), and FIN at cycle t+IN_W+1.
- REQ-016: On entering FIN, bcd SHALL load the work register, ovf SHALL clear, and done SHALL be 1 for that single cycle.
- REQ-017: An out-of-range input SHALL bypass CONV: FIN at t+1 with bcd=32'hFFFF_FFFF, ovf=1 and done=1; busy SHALL never assert.
- REQ-018: FIN SHALL return to IDLE the next cycle unless start=1, in which case REQ-011 applies (back-to-back conversions allowed).
- REQ-019: start while busy=1 SHALL be ignored with no effect on state, counter or outputs; no queueing.
- REQ-020: bcd and ovf SHALL hold their previous result throughout CONV, so the display never shows partial values.
- REQ-021: bin SHALL be sampled only in the accept cycle; later changes to bin SHALL not affect the result.
- REQ-022: No nibble of a completed in-range result SHALL exceed 9.

Reset
- REQ-023: rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, ovf=0, bcd=32'h0000_0000 and clear work, shift and counter registers.
- REQ-024: Reset asserted mid-CONV SHALL abort the conversion; no done pulse SHALL follow, and bcd SHALL stay 0 until a new conversion completes.
- REQ-025: After rst_n deasserts, the first start SHALL be accepted on the first rising edge with rst_n=1.

Verification
- REQ-026: start with bin=0 -> busy high for 27 cycles; at t+28 done=1, bcd=32'h0000_0000, ovf=0.
- REQ-027: bin=12_345_678 -> at t+28 bcd=32'h1234_5678; bin=99_999_999 -> bcd=32'h9999_9999; done is a single-cycle pulse in each case.
- REQ-028: bin=100_000_000 -> at t+1 done=1, ovf=1, bcd=32'hFFFF_FFFF, busy stays 0; a following conversion of bin=42 -> bcd=32'h0000_0042, ovf=0.
- REQ-029: start=1 held continuously with bin=7, then bin changed to 9 at t+5 -> first result 32'h0000_0007 at t+28; second conversion accepted in the FIN cycle gives 32'h0000_0009 at t+56.
- REQ-030: Convert 1_000_000 to completion, then start 555 and pulse rst_n low at t+10 -> bcd=0, busy=0, no done; restart with 555 -> bcd=32'h0000_0555.
- REQ-031: Randomised in-range inputs (>=1000 samples) SHALL match a reference decimal model, and every nibble SHALL be <=9.
